dpram_axis_reader: RTL and testbench

Read-side engine for the team's simple dual-port RAM. It accepts a read command (start address and word count) and issues one-word-per-cycle read strobes to the RAM. It absorbs the RAM's fixed read latency and presents the returned words as an AXI-Stream master with full backpressure. Its typical use is draining payload buffers written by the RoCE RX path toward the TX/DMA path.

---
 rtl/dpram_axis_reader.sv | 146 ++++++++++++++
 tb/tb_dpram_axis_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_axis_reader.sv
// Read engine for the simple dual-port RAM: turns {addr,len} commands into one
// read strobe per cycle and streams the returned words out over AXI-Stream.
module dpram_axis_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 16,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  s_cmd_len,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    output logic                  ram_ena,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   CREDIT_LIM = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, READ} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  cmd_rdy, issue, issue_last, credit, push, pop;
    logic [RD_LATENCY-1:0] vld_pipe_q, last_pipe_q;
    logic [CW-1:0]         inflight_q, fifo_cnt_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q;
    logic                  ena_q;

    // Every read in flight already owns a FIFO slot, so the FIFO never overflows.
    assign credit = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < CREDIT_LIM;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        cmd_rdy    = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (s_cmd_valid) begin
                    addr_d  = s_cmd_addr;
                    rem_d   = s_cmd_len;
                    state_d = READ;
                end
            end
            READ: begin
                if (credit) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (rem_q == '0) begin
                        issue_last = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rem_d = rem_q - LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            ena_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            ena_q   <= 1'b1;
        end
    end

    // {valid,last} travel alongside the RAM pipeline; the head lines up with ram_dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            vld_pipe_q[0]  <= issue;
            last_pipe_q[0] <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
        end
    end

    assign push = vld_pipe_q[RD_LATENCY-1];
    assign pop  = (fifo_cnt_q != '0) && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (issue && !push)      inflight_q <= inflight_q + CW'(1);
            else if (!issue && push) inflight_q <= inflight_q - CW'(1);
            if (push && !pop)        fifo_cnt_q <= fifo_cnt_q + CW'(1);
            else if (!push && pop)   fifo_cnt_q <= fifo_cnt_q - CW'(1);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= ram_dout;
            last_mem_q[wr_ptr_q] <= last_pipe_q[RD_LATENCY-1];
        end
    end

    assign s_cmd_ready   = cmd_rdy && !rst;
    assign ram_ena       = ena_q;
    assign ram_ren       = issue && !rst;
    assign ram_raddr     = addr_q;
    assign m_axis_tvalid = (fifo_cnt_q != '0);
    assign m_axis_tdata  = data_mem_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && last_mem_q[rd_ptr_q];
    assign busy          = (state_q == READ) || (vld_pipe_q != '0) || (fifo_cnt_q != '0);

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !pop) |-> (fifo_cnt_q < DEPTH_CNT));

endmodule

// File: tb/tb_dpram_axis_reader.sv
// Bench for dpram_axis_reader: latency-accurate RAM model plus a command-level
// model of the expected read addresses and stream beats.
module tb_dpram_axis_reader;
    localparam int AW = 16, DW = 128, LW = 16, LAT = 3, DEPTH = 8;

    logic          clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] s_cmd_addr = '0;
    logic [LW-1:0] s_cmd_len = '0;
    logic          s_cmd_valid = 1'b0, s_cmd_ready;
    logic          ram_ena, ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout, m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast, busy;

    always #5 clk = ~clk;

    dpram_axis_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                        .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .ram_ena(ram_ena), .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy));

    logic [31:0] salt = 32'h1234_5678;

    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        return {salt ^ {16'h0, a}, {a, ~a}, {16'h0, a} * 32'h9E37_79B1, ~salt + {16'h0, a}};
    endfunction

    // RAM: data for a strobe in cycle C is presented during cycle C+LAT, junk otherwise.
    logic [AW-1:0] ap [LAT] = '{default: '0};
    logic          vp [LAT] = '{default: 1'b0};
    always @(posedge clk) begin
        ap[0] <= ram_raddr;
        vp[0] <= ram_ren;
        for (int i = 1; i < LAT; i++) begin
            ap[i] <= ap[i-1];
            vp[i] <= vp[i-1];
        end
    end
    assign ram_dout = vp[LAT-1] ? f(ap[LAT-1]) : {4{32'hDEAD_BEEF}};

    int vectors = 0, miscompares = 0, cyc_n = 0, mode = 0, outstanding = 0, max_out = 0;
    int ren_first, ren_last, ren_cnt, beat_first, beat_last, beat_cnt, hs_cyc;
    bit hs_seen, stall_prev;
    logic [DW:0] held;
    logic [AW-1:0] exp_addr_q [$];
    logic [DW:0]   exp_beat_q [$];

    task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_trk();
        ren_first = -1; ren_last = -1; ren_cnt = 0;
        beat_first = -1; beat_last = -1; beat_cnt = 0; max_out = 0;
    endtask

    // Evaluates the current cycle with the inputs the next rising edge will sample.
    task automatic observe();
        if (rst) begin
            chk_i("rst_ready", 32'(s_cmd_ready), 32'd0);
            chk_i("rst_ren", 32'(ram_ren), 32'd0);
            return;
        end
        if (ram_ren === 1'b1) begin
            chk_i("credit", 32'(outstanding < DEPTH), 32'd1);
            chk_i("ren_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) chk_i("raddr", 32'(ram_raddr), 32'(exp_addr_q.pop_front()));
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
            if (ren_first < 0) ren_first = cyc_n;
            ren_last = cyc_n;
            ren_cnt++;
        end
        if (s_cmd_valid && s_cmd_ready === 1'b1) begin
            hs_seen = 1'b1;
            hs_cyc  = cyc_n;
            for (int i = 0; i <= int'(s_cmd_len); i++) begin
                logic [AW-1:0] a;
                a = s_cmd_addr + AW'(i);
                exp_addr_q.push_back(a);
                exp_beat_q.push_back({i == int'(s_cmd_len), f(a)});
            end
        end
        if (m_axis_tvalid === 1'b1) begin
            if (stall_prev) chk_b("hold", {m_axis_tlast, m_axis_tdata}, held);
            if (m_axis_tready) begin
                chk_i("beat_expected", 32'(exp_beat_q.size() != 0), 32'd1);
                if (exp_beat_q.size() != 0)
                    chk_b("beat", {m_axis_tlast, m_axis_tdata}, exp_beat_q.pop_front());
                outstanding--;
                if (beat_first < 0) beat_first = cyc_n;
                beat_last = cyc_n;
                beat_cnt++;
            end
            stall_prev = !m_axis_tready;
            held = {m_axis_tlast, m_axis_tdata};
        end else begin
            if (stall_prev) chk_i("hold_valid", 32'(m_axis_tvalid), 32'd1);
            stall_prev = 1'b0;
        end
    endtask

    task automatic cyc();
        case (mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (cyc_n % 4 == 0);
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        #1 observe();
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        rst = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        outstanding = 0;
        stall_prev  = 1'b0;
        #1;
        chk_i("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk_i("post_rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk_i("post_rst_busy", 32'(busy), 32'd0);
        chk_i("post_rst_ena", 32'(ram_ena), 32'd0);
        chk_i("post_rst_ren", 32'(ram_ren), 32'd0);
        chk_i("post_rst_raddr", 32'(ram_raddr), 32'd0);
        chk_i("post_rst_ready", 32'(s_cmd_ready), 32'd1);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l);
        s_cmd_addr  = a;
        s_cmd_len   = l;
        s_cmd_valid = 1'b1;
        hs_seen     = 1'b0;
        for (int n = 0; n < 2000 && !hs_seen; n++) cyc();
        if (!hs_seen) chk_i("cmd_timeout", 32'(hs_seen), 32'd1);
        s_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000; n++) begin
            if (exp_beat_q.size() == 0 && busy === 1'b0) break;
            cyc();
        end
        chk_i("drain_busy", 32'(busy), 32'd0);
        chk_i("drain_left", 32'(exp_beat_q.size()), 32'd0);
    endtask

    initial begin
        int hs_a;
        @(negedge clk);
        do_reset(2);
        cyc();
        chk_i("ena_after_rst", 32'(ram_ena), 32'd1);

        // Single word: ren at T+1, beat at T+2+LAT.
        clear_trk(); mode = 0;
        send(16'h0010, 16'd0);
        drain();
        chk_i("single_ren_cyc", 32'(ren_first), 32'(hs_cyc + 1));
        chk_i("single_ren_cnt", 32'(ren_cnt), 32'd1);
        chk_i("single_beat_cyc", 32'(beat_first), 32'(hs_cyc + 2 + LAT));
        chk_i("single_beat_cnt", 32'(beat_cnt), 32'd1);

        // Burst of 16 at full throughput.
        clear_trk(); salt = $urandom;
        send(16'h0100, 16'd15);
        drain();
        chk_i("burst_ren_cnt", 32'(ren_cnt), 32'd16);
        chk_i("burst_ren_span", 32'(ren_last - ren_first), 32'd15);
        chk_i("burst_beat_cnt", 32'(beat_cnt), 32'd16);
        chk_i("burst_beat_span", 32'(beat_last - beat_first), 32'd15);
        chk_i("burst_first_beat", 32'(beat_first), 32'(hs_cyc + 2 + LAT));

        // Backpressure: one ready cycle in four; credit must fill to exactly DEPTH.
        clear_trk(); mode = 1; salt = $urandom;
        send(16'($urandom), 16'd31);
        drain();
        chk_i("bp_beat_cnt", 32'(beat_cnt), 32'd32);
        chk_i("bp_max_outstanding", 32'(max_out), 32'(DEPTH));

        // Address wrap across the top of the space.
        clear_trk(); mode = 0;
        send(16'hFFFE, 16'd3);
        drain();
        chk_i("wrap_beat_cnt", 32'(beat_cnt), 32'd4);

        // Back-to-back commands: B accepted the cycle after A's last issue.
        clear_trk();
        send(16'h0000, 16'd3);
        hs_a = hs_cyc;
        send(16'h0020, 16'd1);
        chk_i("b2b_accept_cyc", 32'(hs_cyc), 32'(hs_a + 3 + 2));
        drain();
        chk_i("b2b_beat_cnt", 32'(beat_cnt), 32'd6);

        // Reset mid-burst after 5 beats; nothing stale may follow.
        clear_trk();
        send(16'h0200, 16'd15);
        for (int n = 0; n < 200 && beat_cnt < 5; n++) cyc();
        chk_i("rst_mid_beats", 32'(beat_cnt), 32'd5);
        do_reset(1);
        for (int n = 0; n < 12; n++) cyc();
        clear_trk();
        send(16'h0040, 16'd0);
        drain();
        chk_i("rst_after_beat_cnt", 32'(beat_cnt), 32'd1);

        // Random commands under random backpressure.
        mode = 2; salt = $urandom;
        for (int k = 0; k < 8; k++) begin
            send(16'($urandom), 16'($urandom_range(0, 40)));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
